// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t    fetch FSM states (IDLE/REQ/HOLD/ERR)
//   OPCODE_MSB/LSB opcode field position inside an instruction word
//   BR_OFF_W       width of the PC-relative branch offset field
//   BR_OPCODE_DEF  default opcode value marking a relative branch
//   is_misaligned  true when a PC is not word aligned
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } ifu_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int BR_OFF_W   = 26;

  localparam logic [5:0] BR_OPCODE_DEF = 6'b000010;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ifu_branch_decode.sv
// ifu_branch_decode: combinational relative-branch decode of the instruction
// currently presented to decode.
//   instr_i    in  32  instruction word
//   valid_i    in  1   instruction word is valid
//   pc_src_o   out 1   instruction is a PC-relative branch
//   br_const_o out 32  sign-extended word offset of the branch
// Both outputs are forced to zero while valid_i is low so the PC never sees
// a stale offset.
module ifu_branch_decode
  import proc_pkg::*;
#(
  parameter logic [5:0] BR_OPCODE = BR_OPCODE_DEF
) (
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        pc_src_o,
  output logic [31:0] br_const_o
);

  // Opcode compare and sign extension of the offset field.
  always_comb begin
    pc_src_o   = 1'b0;
    br_const_o = 32'h0000_0000;
    if (valid_i) begin
      pc_src_o   = (instr_i[OPCODE_MSB:OPCODE_LSB] == BR_OPCODE);
      br_const_o = {{(32-BR_OFF_W){instr_i[BR_OFF_W-1]}}, instr_i[BR_OFF_W-1:0]};
    end else begin
      pc_src_o   = 1'b0;
      br_const_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the instruction at each new PC over an imem
// req/ack handshake and hands it to decode with valid/ready. Also reports
// relative branches (pcSrc/pc_const) back to the program counter and holds
// the PC via fetch_stall while a fetch is outstanding.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   pc_in, pc_valid   new PC; taken only while fetch_stall is low
//   imem_req/addr     memory request, held (address stable) until imem_ack
//   imem_ack/rdata    memory response, data valid with ack
//   instr_out/pc      instruction and its address, valid with instr_valid
//   instr_ready       decode accepts the instruction
//   pcSrc, pc_const   relative-branch flag and word offset (the offset port
//                     cannot be called "const", which is a reserved word)
//   fetch_stall       PC must hold
//   fetch_err         sticky: misaligned PC or memory timeout; cleared by RESET
//
// Build option IFETCH_SKID_EN: adds a one-entry skid buffer so the next fetch
// can run in the background while an instruction waits in HOLD.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [5:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter int         TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pcSrc,
  output logic [31:0]       pc_const,
  output logic              fetch_stall,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_go_s;
  logic              accept_s;

`ifdef IFETCH_SKID_EN
  // bg_busy: a request issued from HOLD is outstanding; it reserves the skid
  logic              bg_busy_q, bg_busy_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
`endif

  assign instr_valid = (state_q == HOLD);
  assign fetch_err   = (state_q == ERR);
  assign imem_addr   = addr_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign pc_go_s     = pc_valid & ~fetch_stall;
  assign accept_s    = instr_valid & instr_ready;

`ifdef IFETCH_SKID_EN
  assign imem_req = (state_q == REQ) | bg_busy_q;
`else
  assign imem_req = (state_q == REQ);
`endif

  ifu_branch_decode #(
    .BR_OPCODE (BR_OPCODE)
  ) u_br_dec (
    .instr_i    (instr_q[31:0]),
    .valid_i    (instr_valid),
    .pc_src_o   (pcSrc),
    .br_const_o (pc_const)
  );

  // Stall decision: only IDLE (and, with the skid, an unblocked HOLD) lets the PC move.
  always_comb begin
    fetch_stall = 1'b1;
    case (state_q)
      IDLE:    fetch_stall = 1'b0;
`ifdef IFETCH_SKID_EN
      // no background fetch past a branch, nor with the skid already claimed
      HOLD:    fetch_stall = skid_vld_q | bg_busy_q | pcSrc;
`else
      HOLD:    fetch_stall = 1'b1;
`endif
      default: fetch_stall = 1'b1;
    endcase
  end

  // Next-state logic for the fetch FSM, timeout counter and skid buffer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
`ifdef IFETCH_SKID_EN
    bg_busy_d  = bg_busy_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (pc_go_s) begin
          addr_d  = pc_in;
          cnt_d   = '0;
          state_d = is_misaligned(pc_in[1:0]) ? ERR : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          state_d = HOLD;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
`ifdef IFETCH_SKID_EN
        if (bg_busy_q && !imem_ack && (cnt_q == TO_LAST)) begin
          bg_busy_d = 1'b0;
          state_d   = ERR;
        end else if (accept_s) begin
          if (skid_vld_q) begin
            // promote the buffered word; it appears on the cycle after the handshake
            instr_d    = skid_q;
            ipc_d      = skid_pc_q;
            skid_vld_d = 1'b0;
          end else if (bg_busy_q && imem_ack) begin
            instr_d   = imem_rdata;
            ipc_d     = addr_q;
            bg_busy_d = 1'b0;
          end else if (bg_busy_q) begin
            // background request still pending: it becomes the foreground one
            bg_busy_d = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = REQ;
          end else if (pc_go_s) begin
            addr_d  = pc_in;
            cnt_d   = '0;
            state_d = is_misaligned(pc_in[1:0]) ? ERR : REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (bg_busy_q && imem_ack) begin
          skid_d     = imem_rdata;
          skid_pc_d  = addr_q;
          skid_vld_d = 1'b1;
          bg_busy_d  = 1'b0;
        end else if (bg_busy_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (pc_go_s) begin
          addr_d = pc_in;
          cnt_d  = '0;
          if (is_misaligned(pc_in[1:0])) begin
            state_d = ERR;
          end else begin
            bg_busy_d = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
`else
        if (accept_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
`endif
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef IFETCH_SKID_EN
  // Skid buffer and background-request registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bg_busy_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      bg_busy_q  <= bg_busy_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
`ifdef IFETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              CLK;
  logic              RESET;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              pcSrc;
  logic [31:0]       pc_const;
  logic              fetch_stall;
  logic              fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BR_OPCODE (6'b000010), .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK (CLK), .RESET (RESET), .pc_in (pc_in), .pc_valid (pc_valid),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack),
    .imem_rdata (imem_rdata), .instr_out (instr_out), .instr_pc (instr_pc),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .pcSrc (pcSrc),
    .pc_const (pc_const), .fetch_stall (fetch_stall), .fetch_err (fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules: branch iff opcode field is 2, offset is the signed 26-bit field.
  function automatic logic model_src(input logic [31:0] w);
    return (w[31:26] == 6'd2);
  endfunction

  function automatic logic [31:0] model_const(input logic [31:0] w);
    int off;
    off = int'(w[25:0]);
    if (off >= (1 << 25)) off = off - (1 << 26);
    return 32'(off);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b0; pc_valid = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    step(); step();
    RESET = 1'b1;
    step();
  endtask

  // One complete fetch from IDLE back to IDLE, checking every cycle.
  task automatic fetch_txn(input logic [31:0] pc, input logic [31:0] data,
                           input int ack_dly, input int rdy_dly, input bit pulse,
                           input string tag);
    logic        exp_src;
    logic [31:0] exp_const;
    logic        exp_hold_stall;
    exp_src        = model_src(data);
    exp_const      = model_const(data);
    exp_hold_stall = SKID ? exp_src : 1'b1;
    pc_in = pc; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int i = 0; i <= ack_dly; i++) begin
      n_tests++;
      if ({imem_req, imem_addr, fetch_stall, instr_valid, pcSrc, pc_const} !==
          {1'b1, pc, 1'b1, 1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL %s req_phase cyc%0d: req=%b addr=%h stall=%b iv=%b src=%b const=%h, expected req=1 addr=%h stall=1 iv=0 src=0 const=0",
                 tag, i, imem_req, imem_addr, fetch_stall, instr_valid, pcSrc, pc_const, pc);
      end
      if (i < ack_dly) begin
        if (pulse) begin
          pc_in = pc + 32'h40; pc_valid = ~pc_valid;
        end
        step();
      end
    end
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; imem_rdata = $urandom; pc_valid = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      n_tests++;
      if ({instr_valid, instr_out, instr_pc, pcSrc, pc_const, fetch_stall, imem_req} !==
          {1'b1, data, pc, exp_src, exp_const, exp_hold_stall, 1'b0}) begin
        n_fail++;
        $display("FAIL %s hold_phase cyc%0d: iv=%b instr=%h ipc=%h src=%b const=%h stall=%b req=%b, expected iv=1 instr=%h ipc=%h src=%b const=%h stall=%b req=0",
                 tag, i, instr_valid, instr_out, instr_pc, pcSrc, pc_const, fetch_stall, imem_req,
                 data, pc, exp_src, exp_const, exp_hold_stall);
      end
      instr_ready = (i == rdy_dly);
      if (pulse && !SKID) begin
        pc_in = pc + 32'h80; pc_valid = 1'($urandom_range(0, 1));
      end
      step();
    end
    instr_ready = 1'b0; pc_valid = 1'b0;
    n_tests++;
    if ({instr_valid, imem_req, fetch_stall, fetch_err, pcSrc, pc_const} !== 36'h0) begin
      n_fail++;
      $display("FAIL %s back_to_idle: iv=%b req=%b stall=%b err=%b src=%b const=%h, expected all 0",
               tag, instr_valid, imem_req, fetch_stall, fetch_err, pcSrc, pc_const);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; pc_in = 32'h0; pc_valid = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b0;
    step(); step();
    n_tests++;
    if ({imem_req, imem_addr, instr_out, instr_pc, instr_valid, pcSrc, pc_const, fetch_stall, fetch_err} !== 133'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h ipc=%h iv=%b src=%b const=%h stall=%b err=%b, expected all 0",
               imem_req, imem_addr, instr_out, instr_pc, instr_valid, pcSrc, pc_const, fetch_stall, fetch_err);
    end
    RESET = 1'b1;
    step();
  endtask

  task automatic test_basic();
    fetch_txn(32'h100, 32'h8C01_0004, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_branch();
    fetch_txn(32'h104, 32'h0BFF_FFFE, 0, 0, 1'b0, "branch_neg");
    fetch_txn(32'h108, 32'h0800_0003, 0, 1, 1'b0, "branch_pos");
  endtask

  task automatic test_stall();
    fetch_txn(32'h10C, 32'h1234_5678, 5, 3, 1'b1, "stall");
    fetch_txn(32'h110, 32'h0A00_0000, TIMEOUT - 1, 0, 1'b0, "ack_at_limit");
  endtask

  task automatic test_stray_ack();
    imem_ack = 1'b1; imem_rdata = 32'h0800_0001;
    step();
    imem_ack = 1'b0;
    step();
    n_tests++;
    if ({instr_valid, imem_req, fetch_stall, pcSrc} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stray_ack_idle: iv=%b req=%b stall=%b src=%b, expected 0 0 0 0",
               instr_valid, imem_req, fetch_stall, pcSrc);
    end
  endtask

  task automatic test_misaligned();
    pc_in = 32'h102; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    n_tests++;
    if ({imem_req, fetch_err, fetch_stall, instr_valid} !== 4'b0110) begin
      n_fail++;
      $display("FAIL misaligned: req=%b err=%b stall=%b iv=%b, expected 0 1 1 0",
               imem_req, fetch_err, fetch_stall, instr_valid);
    end
    pc_in = 32'h104; pc_valid = 1'b1; imem_ack = 1'b1;
    step(); step();
    pc_valid = 1'b0; imem_ack = 1'b0;
    n_tests++;
    if ({imem_req, fetch_err, fetch_stall, instr_valid} !== 4'b0110) begin
      n_fail++;
      $display("FAIL err_sticky: req=%b err=%b stall=%b iv=%b, expected 0 1 1 0",
               imem_req, fetch_err, fetch_stall, instr_valid);
    end
    apply_reset();
    n_tests++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared_by_reset: err=%b, expected 0", fetch_err);
    end
  endtask

  task automatic test_timeout();
    pc_in = 32'h300; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    repeat (TIMEOUT - 1) step();
    n_tests++;
    if ({imem_req, fetch_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_not_yet: req=%b err=%b, expected 1 0", imem_req, fetch_err);
    end
    step();
    n_tests++;
    if ({imem_req, fetch_err, fetch_stall, instr_valid} !== 4'b0110) begin
      n_fail++;
      $display("FAIL timeout_err: req=%b err=%b stall=%b iv=%b, expected 0 1 1 0",
               imem_req, fetch_err, fetch_stall, instr_valid);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_req();
    pc_in = 32'h400; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_out, instr_pc, instr_valid, pcSrc, pc_const, fetch_stall, fetch_err} !== 133'h0) begin
      n_fail++;
      $display("FAIL reset_mid_req: req=%b addr=%h instr=%h ipc=%h iv=%b stall=%b err=%b, expected all 0",
               imem_req, imem_addr, instr_out, instr_pc, instr_valid, fetch_stall, fetch_err);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    RESET = 1'b1;
    step();
    imem_ack = 1'b0;
    n_tests++;
    if ({instr_valid, imem_req, fetch_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_ack_after_reset: iv=%b req=%b stall=%b, expected 0 0 0",
               instr_valid, imem_req, fetch_stall);
    end
    fetch_txn(32'h404, 32'h0800_0010, 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] data;
    for (int n = 0; n < 25; n++) begin
      pc = $urandom;
      pc[1:0] = 2'b00;
      data = $urandom;
      if ($urandom_range(0, 1) == 1) data[31:26] = 6'b000010;
      fetch_txn(pc, data, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), "random");
    end
  endtask

`ifdef IFETCH_SKID_EN
  task automatic test_back_to_back();
    pc_in = 32'h200; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    step();
    imem_ack = 1'b0;
    n_tests++;
    if ({instr_valid, instr_out, fetch_stall} !== {1'b1, 32'h1111_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: iv=%b instr=%h stall=%b, expected 1 11110000 0",
               instr_valid, instr_out, fetch_stall);
    end
    pc_in = 32'h204; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    n_tests++;
    if ({imem_req, imem_addr, instr_out, fetch_stall} !== {1'b1, 32'h204, 32'h1111_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_bg_req: req=%b addr=%h instr=%h stall=%b, expected 1 204 11110000 1",
               imem_req, imem_addr, instr_out, fetch_stall);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2222_0000; instr_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    n_tests++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h2222_0000, 32'h204}) begin
      n_fail++;
      $display("FAIL b2b_second: iv=%b instr=%h ipc=%h, expected 1 22220000 204",
               instr_valid, instr_out, instr_pc);
    end
    step();
    instr_ready = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: iv=%b, expected 0", instr_valid);
    end
    pc_in = 32'h208; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0800_0005;
    step();
    imem_ack = 1'b0; pc_in = 32'h20C; pc_valid = 1'b1;
    step();
    n_tests++;
    if ({fetch_stall, imem_req, pcSrc} !== 3'b101) begin
      n_fail++;
      $display("FAIL branch_blocks_bg: stall=%b req=%b src=%b, expected 1 0 1",
               fetch_stall, imem_req, pcSrc);
    end
    pc_valid = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_stray_ack();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_random();
`ifdef IFETCH_SKID_EN
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
